// File: rtl/sfq_mon_pkg.sv
// Shared types, defaults and helpers for the SFQ pulse deserializer.
package sfq_mon_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 4;
  localparam int unsigned DEF_MAX_W = 4;

  // Capture window state: IDLE until the first SFQ clock pulse, then a window is always open.
  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } win_state_e;

  // Ceiling log2, never below 1, so derived counters and pointers keep a legal width.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sfq_word_fifo.sv
// Small synchronous word FIFO. The head word sits in its own register so the
// consumer sees a flop output that stays stable until it pops.
module sfq_word_fifo
  import sfq_mon_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] CAP = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic             do_push;
  logic             do_pop;
  logic [AW-1:0]    rd_ptr_nxt;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] head_nxt;

  // Status flags decoded from the occupancy register.
  always_comb begin
    full  = (count == CAP);
    empty = (count == '0);
  end

  // Next-state decode; a pop on a full FIFO frees the slot for a same-cycle push.
  // The next head is taken from din when the slot being written becomes the head.
  always_comb begin
    do_pop     = pop && !empty;
    do_push    = push && (!full || do_pop);
    rd_ptr_nxt = do_pop ? rd_ptr + 1'b1 : rd_ptr;
    count_nxt  = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
    if (count_nxt == '0) begin
      head_nxt = '0;
    end else if (do_push && (wr_ptr == rd_ptr_nxt)) begin
      head_nxt = din;
    end else begin
      head_nxt = mem[rd_ptr_nxt];
    end
  end

  // Storage, pointers, occupancy and head register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      head   <= head_nxt;
    end
  end

endmodule

// File: rtl/sfq_pulse_deserializer.sv
// Collects the dout pulse train of an SFQ cell against its clock pulse train,
// packs one bit per SFQ period into LSB-first words and queues them in a FIFO.
module sfq_pulse_deserializer
  import sfq_mon_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned MAX_W = DEF_MAX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sfq_clk,
  input  logic             sfq_dout,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             clr_err,
  output logic             overflow,
  output logic             dbl_err,
  output logic             width_err
);

  localparam int unsigned BCW = clog2(WIDTH);
  localparam int unsigned HCW = clog2(MAX_W + 2);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);
  localparam logic [HCW-1:0] HI_LIMIT = HCW'(MAX_W + 1);

  logic             sclk_q;
  logic             sclk_p;
  logic             dout_q;
  logic             dout_p;
  logic             sclk_edge;
  logic             dout_edge;

  win_state_e       state;
  logic             hit;
  logic [BCW-1:0]   bit_cnt;
  logic [WIDTH-1:0] acc;
  logic [HCW-1:0]   hi_cnt;

  logic             win_bit;
  logic [WIDTH-1:0] acc_nxt;
  logic             word_done;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             dbl_set;
  logic             ovf_set;
  logic             width_set;

  // Input sample, one-cycle history and registered rising-edge flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q    <= 1'b0;
      sclk_p    <= 1'b0;
      dout_q    <= 1'b0;
      dout_p    <= 1'b0;
      sclk_edge <= 1'b0;
      dout_edge <= 1'b0;
    end else begin
      sclk_q    <= sfq_clk;
      sclk_p    <= sclk_q;
      dout_q    <= sfq_dout;
      dout_p    <= dout_q;
      sclk_edge <= sclk_q & ~sclk_p;
      dout_edge <= dout_q & ~dout_p;
    end
  end

  // Closing-bit value, accumulator update and error/push decode.
  // A data edge coincident with the closing clock edge still belongs to the closing window.
  always_comb begin
    win_bit          = hit | dout_edge;
    acc_nxt          = acc;
    acc_nxt[bit_cnt] = win_bit;
    word_done        = (state == OPEN) && sclk_edge && (bit_cnt == LAST_BIT);
    pop              = out_valid && out_ready;
    dbl_set          = (state == OPEN) && dout_edge && hit;
    ovf_set          = word_done && fifo_full && !pop;
    width_set        = (hi_cnt == HI_LIMIT);
  end

  // Window FSM: opens on the first SFQ clock pulse, then each pulse closes one bit and reopens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      hit     <= 1'b0;
      bit_cnt <= '0;
      acc     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sclk_edge) begin
            state   <= OPEN;
            hit     <= 1'b0;
            bit_cnt <= '0;
          end
        end
        OPEN: begin
          if (sclk_edge) begin
            hit     <= 1'b0;
            acc     <= word_done ? '0 : acc_nxt;
            bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
          end else if (dout_edge) begin
            hit <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // High-run length of the sampled data line, saturating one past the legal maximum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_cnt <= '0;
    end else if (!dout_q) begin
      hi_cnt <= '0;
    end else if (hi_cnt != HI_LIMIT) begin
      hi_cnt <= hi_cnt + 1'b1;
    end
  end

  // Sticky flags; a new error in the clear cycle keeps its flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      dbl_err   <= 1'b0;
      width_err <= 1'b0;
    end else begin
      overflow  <= ovf_set   | (overflow  & ~clr_err);
      dbl_err   <= dbl_set   | (dbl_err   & ~clr_err);
      width_err <= width_set | (width_err & ~clr_err);
    end
  end

  // Output valid follows FIFO occupancy.
  always_comb begin
    out_valid = ~fifo_empty;
  end

  sfq_word_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (word_done),
    .din  (acc_nxt),
    .pop  (pop),
    .full (fifo_full),
    .empty(fifo_empty),
    .head (out_data)
  );

endmodule

// File: tb/tb_sfq_pulse_deserializer.sv
// Directed bench for sfq_pulse_deserializer: single-word vectors from a table,
// plus hand-written sequences for FIFO overflow, width errors and mid-word reset.
module tb_sfq_pulse_deserializer;

  logic       clk;
  logic       rst;
  logic       sfq_clk;
  logic       sfq_dout;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       clr_err;
  logic       overflow;
  logic       dbl_err;
  logic       width_err;

  int total;
  int bad;

  typedef struct {
    logic [7:0] word;      // trailing data pulse per bit
    logic [7:0] coinc;     // extra data pulse coincident with the pulse closing that bit
    logic [7:0] dbl;       // bit gets two trailing data pulses
    logic [7:0] exp_word;
    logic       exp_dbl;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  sfq_pulse_deserializer #(
    .WIDTH(8),
    .DEPTH(4),
    .MAX_W(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sfq_clk  (sfq_clk),
    .sfq_dout (sfq_dout),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .clr_err  (clr_err),
    .overflow (overflow),
    .dbl_err  (dbl_err),
    .width_err(width_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sfq_clk = 1'b0;
    sfq_dout = 1'b0;
    clr_err = 1'b0;
    ticks(2);
    rst = 1'b0;
    tick();
  endtask

  // One 10-cycle SFQ period: clock pulse at offset 0 (2 cycles high), optional
  // coincident data pulse at offset 0, then either a data pulse at offset 5 or
  // two data pulses at offsets 3 and 6.
  task automatic sfq_pulse(input logic coinc, input logic data, input logic dbl);
    sfq_clk = 1'b1;
    sfq_dout = coinc;
    ticks(2);
    sfq_clk = 1'b0;
    sfq_dout = 1'b0;
    tick();
    if (dbl) begin
      sfq_dout = 1'b1;
      ticks(2);
      sfq_dout = 1'b0;
      tick();
      sfq_dout = 1'b1;
      ticks(2);
      sfq_dout = 1'b0;
      ticks(2);
    end else begin
      ticks(2);
      sfq_dout = data;
      ticks(2);
      sfq_dout = 1'b0;
      ticks(3);
    end
  endtask

  task automatic send_word(input logic [7:0] w, input logic [7:0] d);
    for (int j = 0; j < 8; j++) sfq_pulse(1'b0, w[j], d[j]);
  endtask

  task automatic drain_expect(input string name, input logic [7:0] w);
    out_ready = 1'b1;
    chk({name, "_valid"}, out_valid, 1'b1);
    chk({name, "_data"}, out_data, w);
    tick();
    out_ready = 1'b0;
  endtask

  task automatic clr_pulse();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    tick();
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    sfq_clk = 1'b0;
    sfq_dout = 1'b0;
    out_ready = 1'b0;
    clr_err = 1'b0;

    vecs[0] = '{word: 8'h4D, coinc: 8'h00, dbl: 8'h00, exp_word: 8'h4D, exp_dbl: 1'b0};
    vecs[1] = '{word: 8'h04, coinc: 8'h09, dbl: 8'h00, exp_word: 8'h0D, exp_dbl: 1'b0};
    vecs[2] = '{word: 8'h10, coinc: 8'h00, dbl: 8'h10, exp_word: 8'h10, exp_dbl: 1'b1};
    vecs[3] = '{word: 8'hFF, coinc: 8'h00, dbl: 8'h00, exp_word: 8'hFF, exp_dbl: 1'b0};
    vecs[4] = '{word: 8'h00, coinc: 8'h00, dbl: 8'h00, exp_word: 8'h00, exp_dbl: 1'b0};
    vecs[5] = '{word: 8'h81, coinc: 8'h80, dbl: 8'h00, exp_word: 8'h81, exp_dbl: 1'b1};
    vecs[6] = '{word: 8'h01, coinc: 8'h80, dbl: 8'h00, exp_word: 8'h81, exp_dbl: 1'b0};

    // Reset state
    ticks(2);
    chk("rst_data", out_data, 8'h00);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_dbl", dbl_err, 1'b0);
    chk("rst_width", width_err, 1'b0);
    rst = 1'b0;
    tick();

    // Table-driven single words, each followed by a hand-timed closing pulse
    for (int v = 0; v < NV; v++) begin
      logic c;
      do_reset();
      out_ready = 1'b0;
      for (int j = 0; j < 8; j++) begin
        if (j > 0) c = vecs[v].coinc[j-1];
        else       c = 1'b0;
        sfq_pulse(c, vecs[v].word[j], vecs[v].dbl[j]);
      end
      sfq_clk = 1'b1;
      sfq_dout = vecs[v].coinc[7];
      ticks(2);
      chk($sformatf("v%0d_valid_early", v), out_valid, 1'b0);
      sfq_clk = 1'b0;
      sfq_dout = 1'b0;
      tick();
      chk($sformatf("v%0d_valid_latency", v), out_valid, 1'b1);
      ticks(4);
      chk($sformatf("v%0d_data", v), out_data, vecs[v].exp_word);
      chk($sformatf("v%0d_dbl", v), dbl_err, vecs[v].exp_dbl);
      chk($sformatf("v%0d_overflow", v), overflow, 1'b0);
      chk($sformatf("v%0d_width", v), width_err, 1'b0);
    end

    // Five words into a 4-deep FIFO with the consumer stalled, one double pulse
    do_reset();
    out_ready = 1'b0;
    send_word(8'h11, 8'h00);
    send_word(8'h5A, 8'h10);
    send_word(8'h33, 8'h00);
    send_word(8'hC4, 8'h00);
    send_word(8'h77, 8'h00);
    sfq_pulse(1'b0, 1'b0, 1'b0);
    ticks(2);
    chk("ovf_overflow", overflow, 1'b1);
    chk("ovf_dbl", dbl_err, 1'b1);
    chk("ovf_width", width_err, 1'b0);
    chk("ovf_head_stable", out_data, 8'h11);
    drain_expect("ovf_w1", 8'h11);
    drain_expect("ovf_w2", 8'h5A);
    drain_expect("ovf_w3", 8'h33);
    drain_expect("ovf_w4", 8'hC4);
    chk("ovf_empty", out_valid, 1'b0);
    clr_pulse();
    chk("ovf_clr_overflow", overflow, 1'b0);
    chk("ovf_clr_dbl", dbl_err, 1'b0);

    // Data-line width check: MAX_W high is legal, longer is not
    do_reset();
    sfq_dout = 1'b1;
    ticks(4);
    sfq_dout = 1'b0;
    ticks(5);
    chk("width_at_max", width_err, 1'b0);
    sfq_dout = 1'b1;
    ticks(6);
    sfq_dout = 1'b0;
    ticks(5);
    chk("width_over", width_err, 1'b1);
    clr_pulse();
    chk("width_clr", width_err, 1'b0);
    chk("width_clr_dbl", dbl_err, 1'b0);
    chk("width_clr_overflow", overflow, 1'b0);
    sfq_dout = 1'b1;
    ticks(8);
    clr_pulse();
    chk("width_err_wins", width_err, 1'b1);
    sfq_dout = 1'b0;
    ticks(5);
    clr_pulse();
    chk("width_clr2", width_err, 1'b0);

    // Asynchronous reset in the middle of a word, stray data pulse while idle
    do_reset();
    out_ready = 1'b0;
    send_word(8'h3C, 8'h00);
    sfq_pulse(1'b0, 1'b1, 1'b0);
    sfq_pulse(1'b0, 1'b1, 1'b0);
    sfq_pulse(1'b0, 1'b1, 1'b0);
    chk("mid_pre_valid", out_valid, 1'b1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_data", out_data, 8'h00);
    tick();
    rst = 1'b0;
    tick();
    sfq_dout = 1'b1;
    ticks(2);
    sfq_dout = 1'b0;
    ticks(5);
    send_word(8'h96, 8'h00);
    sfq_pulse(1'b0, 1'b0, 1'b0);
    chk("mid_word_valid", out_valid, 1'b1);
    chk("mid_word_data", out_data, 8'h96);
    chk("mid_word_dbl", dbl_err, 1'b0);

    // Full FIFO with a pop in the same cycle as the fifth word's push
    do_reset();
    out_ready = 1'b0;
    send_word(8'hA1, 8'h00);
    send_word(8'hB2, 8'h00);
    send_word(8'hC3, 8'h00);
    send_word(8'hD4, 8'h00);
    send_word(8'hE5, 8'h00);
    sfq_clk = 1'b1;
    ticks(2);
    chk("full_pop_head", out_data, 8'hA1);
    out_ready = 1'b1;
    sfq_clk = 1'b0;
    tick();
    out_ready = 1'b0;
    ticks(3);
    chk("full_pop_overflow", overflow, 1'b0);
    drain_expect("full_pop_w2", 8'hB2);
    drain_expect("full_pop_w3", 8'hC3);
    drain_expect("full_pop_w4", 8'hD4);
    drain_expect("full_pop_w5", 8'hE5);
    chk("full_pop_empty", out_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
